// File: rtl/firc_accum_out.sv
// rtl/firc_accum_out.sv - complex FIR output stage: adder tree, beat accumulator, round/shift/narrow
// Optional saturation of the narrowed sample: define FIRC_OUT_SAT_EN.
module firc_accum_out #(
    parameter int NPROD  = 5,
    parameter int PW     = 54,
    parameter int NBEAT  = 3,
    parameter int ACCW   = 60,
    parameter int OSHIFT = 20
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    ValidIn,
    input  logic                    FirstIn,
    input  logic                    LastIn,
    input  logic [NPROD*PW-1:0]     ProdI,
    input  logic [NPROD*PW-1:0]     ProdQ,
    output logic                    PushOut,
    output logic signed [31:0]      FI,
    output logic signed [31:0]      FQ,
    output logic                    SeqErr
);
    typedef enum logic {S_IDLE, S_ACC} state_t;

    localparam logic signed [ACCW:0] RND = (ACCW+1)'(1) << (OSHIFT - 1);
`ifdef FIRC_OUT_SAT_EN
    localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'(64'sh7FFFFFFF);
    localparam logic signed [ACCW:0] SAT_MIN = -SAT_MAX - (ACCW+1)'(1);
`endif

    state_t                 state, state_nxt;
    logic signed [ACCW-1:0] sum_i_c, sum_q_c;
    logic signed [ACCW-1:0] sum_i, sum_q;
    logic signed [ACCW-1:0] acc_i, acc_q;
    logic                   v1, f1, l1;
    logic [7:0]             cnt;
    logic                   load, add, done, err, done2;

    always_comb begin
        sum_i_c = '0;
        sum_q_c = '0;
        for (int k = 0; k < NPROD; k++) begin
            sum_i_c = sum_i_c + {{(ACCW-PW){ProdI[k*PW+PW-1]}}, ProdI[k*PW +: PW]};
            sum_q_c = sum_q_c + {{(ACCW-PW){ProdQ[k*PW+PW-1]}}, ProdQ[k*PW +: PW]};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_i <= '0;
            sum_q <= '0;
            v1    <= 1'b0;
            f1    <= 1'b0;
            l1    <= 1'b0;
        end else begin
            sum_i <= sum_i_c;
            sum_q <= sum_q_c;
            v1    <= ValidIn;
            f1    <= FirstIn;
            l1    <= LastIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (v1 && f1 && !l1) state_nxt = S_ACC;
            S_ACC:  if (v1 && l1)        state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // A First beat always restarts the sample, even if it is also Last.
    always_comb begin
        load = 1'b0;
        add  = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        if (v1) begin
            case (state)
                S_IDLE: begin
                    load = f1;
                    done = f1 && l1;
                    err  = !f1;
                end
                S_ACC: begin
                    load = f1;
                    add  = !f1;
                    done = l1;
                    err  = f1 || (l1 && ((cnt + 8'd1) != 8'(NBEAT)));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_i  <= '0;
            acc_q  <= '0;
            cnt    <= '0;
            done2  <= 1'b0;
            SeqErr <= 1'b0;
        end else begin
            if (load) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= 8'd1;
            end else if (add) begin
                acc_i <= acc_i + sum_i;
                acc_q <= acc_q + sum_q;
                if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            end
            done2  <= done;
            SeqErr <= SeqErr | err;
        end
    end

    // One guard bit so the rounding add cannot overflow the accumulator width.
    function automatic logic [31:0] narrow(input logic signed [ACCW-1:0] a);
`ifdef FIRC_OUT_SAT_EN
        logic signed [ACCW:0] r;
        r = ((ACCW+1)'(a) + RND) >>> OSHIFT;
        if (r > SAT_MAX)      narrow = 32'h7FFFFFFF;
        else if (r < SAT_MIN) narrow = 32'h80000000;
        else                  narrow = r[31:0];
`else
        narrow = 32'(((ACCW+1)'(a) + RND) >>> OSHIFT);
`endif
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PushOut <= 1'b0;
            FI      <= '0;
            FQ      <= '0;
        end else begin
            PushOut <= done2;
            if (done2) begin
                FI <= narrow(acc_i);
                FQ <= narrow(acc_q);
            end
        end
    end
endmodule

// File: tb/tb_firc_accum_out.sv
// tb/tb_firc_accum_out.sv - self-checking bench for firc_accum_out
module tb_firc_accum_out;
    localparam int NPROD = 5;
    localparam int PW    = 54;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 ValidIn, FirstIn, LastIn;
    logic [NPROD*PW-1:0]  ProdI, ProdQ;
    logic                 PushOut;
    logic signed [31:0]   FI, FQ;
    logic                 SeqErr;

    firc_accum_out dut (
        .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .FirstIn(FirstIn), .LastIn(LastIn),
        .ProdI(ProdI), .ProdQ(ProdQ), .PushOut(PushOut), .FI(FI), .FQ(FQ), .SeqErr(SeqErr)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [31:0] fi;
        logic signed [31:0] fq;
        int                 c;
    } push_t;

    push_t got[$];
    push_t exp_q[$];

    always @(negedge Clk) if (PushOut === 1'b1) got.push_back('{FI, FQ, cyc});

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: a sample is the sum of the beats from the latest First
    // through Last; anything else is a framing error.
    longint bi[NPROD];
    longint bq[NPROD];
    bit     m_active, m_seq;
    longint m_ai, m_aq;
    int     m_cnt;

    function automatic logic signed [31:0] narrow(input longint a);
        longint r;
        r = (a + 64'sd524288) >>> 20;
`ifdef FIRC_OUT_SAT_EN
        if (r > 64'sd2147483647)  return 32'sh7FFFFFFF;
        if (r < -64'sd2147483648) return 32'sh80000000;
`endif
        return r[31:0];
    endfunction

    function automatic longint beat_sum(input bit q);
        longint s = 0;
        for (int k = 0; k < NPROD; k++) s += q ? bq[k] : bi[k];
        return s;
    endfunction

    task automatic model_emit();
        exp_q.push_back('{narrow(m_ai), narrow(m_aq), 0});
        m_active = 1'b0;
    endtask

    task automatic model_beat(input bit f, input bit l);
        if (f) begin
            if (m_active) m_seq = 1'b1;
            m_active = 1'b1;
            m_ai = beat_sum(0);
            m_aq = beat_sum(1);
            m_cnt = 1;
            if (l) model_emit();
        end else if (!m_active) begin
            m_seq = 1'b1;
        end else begin
            m_ai += beat_sum(0);
            m_aq += beat_sum(1);
            m_cnt++;
            if (l) begin
                if (m_cnt != 3) m_seq = 1'b1;
                model_emit();
            end
        end
    endtask

    task automatic send(input bit v, input bit f, input bit l);
        ValidIn = v;
        FirstIn = f;
        LastIn  = l;
        for (int k = 0; k < NPROD; k++) begin
            ProdI[k*PW +: PW] = bi[k][PW-1:0];
            ProdQ[k*PW +: PW] = bq[k][PW-1:0];
        end
        if (v) model_beat(f, l);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        ValidIn = 1'b0;
        FirstIn = 1'b0;
        LastIn  = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    task automatic rand_prod();
        longint t;
        for (int k = 0; k < NPROD; k++) begin
            t = {$urandom(), $urandom()};
            bi[k] = t >>> 23;
            t = {$urandom(), $urandom()};
            bq[k] = t >>> 23;
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_seq    = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        idle(2);
        Reset = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic compare_queues(input string name);
        idle(5);
        check($sformatf("%s push count", name), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s FI[%0d]", name, i), got[i].fi, exp_q[i].fi);
            check($sformatf("%s FQ[%0d]", name, i), got[i].fq, exp_q[i].fq);
        end
        got.delete();
        exp_q.delete();
    endtask

    typedef struct {
        longint i0;
        longint q0;
        int     efi;
        int     efq;
    } vec_t;

    initial begin
        vec_t   vecs[6];
        int     c_last;
        longint si, sq;

        Reset = 1'b1;
        ValidIn = 1'b0; FirstIn = 1'b0; LastIn = 1'b0;
        ProdI = '0; ProdQ = '0;
        model_reset();
        #1;
        check("reset PushOut", PushOut, 0);
        check("reset FI", FI, 0);
        check("reset FQ", FQ, 0);
        check("reset SeqErr", SeqErr, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // T1: three beats of 5 * 2^20 -> 15 / -15, three edges after Last
        for (int k = 0; k < NPROD; k++) begin
            bi[k] = 64'sd1048576;
            bq[k] = -64'sd1048576;
        end
        send(1, 1, 0);
        send(1, 0, 0);
        c_last = cyc;
        send(1, 0, 1);
        idle(5);
        check("T1 push count", got.size(), 1);
        if (got.size() >= 1) begin
            check("T1 latency", got[0].c, c_last + 3);
            check("T1 FI", got[0].fi, 15);
            check("T1 FQ", got[0].fq, -15);
        end
        check("T1 SeqErr", SeqErr, 0);
        got.delete();
        exp_q.delete();

        // Single-beat rounding and narrowing boundaries
        vecs[0] = '{64'sd524288, -64'sd524289, 1, -1};
        vecs[1] = '{64'sd524287, -64'sd524288, 0, 0};
        vecs[3] = '{64'sd3145735, -64'sd3145728, 3, -3};
        vecs[4] = '{64'sd2147483647 <<< 20, -64'sd2147483648 <<< 20, 32'sh7FFFFFFF, 32'sh80000000};
`ifdef FIRC_OUT_SAT_EN
        vecs[2] = '{longint'(1) <<< 52, -(longint'(1) <<< 52), 32'sh7FFFFFFF, 32'sh80000000};
        vecs[5] = '{longint'(1) <<< 51, 64'sd0, 32'sh7FFFFFFF, 0};
`else
        vecs[2] = '{longint'(1) <<< 52, -(longint'(1) <<< 52), 0, 0};
        vecs[5] = '{longint'(1) <<< 51, 64'sd0, 32'sh80000000, 0};
`endif
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < NPROD; k++) begin
                bi[k] = 0;
                bq[k] = 0;
            end
            bi[0] = vecs[v].i0;
            bq[0] = vecs[v].q0;
            send(1, 1, 1);
            idle(4);
            check($sformatf("vec%0d push count", v), got.size(), 1);
            if (got.size() >= 1) begin
                check($sformatf("vec%0d FI", v), got[0].fi, vecs[v].efi);
                check($sformatf("vec%0d FQ", v), got[0].fq, vecs[v].efq);
            end
            got.delete();
            exp_q.delete();
        end

        // T4: orphan Last, then an abandoned sample, then a good one
        do_reset();
        rand_prod(); send(1, 0, 1);
        rand_prod(); send(1, 1, 0);
        rand_prod(); send(1, 0, 0);
        rand_prod(); si = beat_sum(0); sq = beat_sum(1); send(1, 1, 0);
        rand_prod(); si += beat_sum(0); sq += beat_sum(1); send(1, 0, 0);
        rand_prod(); si += beat_sum(0); sq += beat_sum(1); send(1, 0, 1);
        idle(5);
        check("T4 push count", got.size(), 1);
        if (got.size() >= 1) begin
            check("T4 FI", got[0].fi, narrow(si));
            check("T4 FQ", got[0].fq, narrow(sq));
        end
        check("T4 SeqErr", SeqErr, 1);
        got.delete();
        exp_q.delete();

        // T5: back-to-back samples, bubbles inside the second
        do_reset();
        rand_prod(); send(1, 1, 0);
        rand_prod(); send(1, 0, 0);
        rand_prod(); send(1, 0, 1);
        rand_prod(); send(1, 1, 0);
        idle(1);
        rand_prod(); send(1, 0, 0);
        idle(1);
        rand_prod(); send(1, 0, 1);
        check("T5 expected pushes", exp_q.size(), 2);
        compare_queues("T5");
        check("T5 SeqErr", SeqErr, 0);

        // T6: reset mid-sample
        do_reset();
        for (int k = 0; k < NPROD; k++) begin
            bi[k] = 64'sd1048576;
            bq[k] = -64'sd1048576;
        end
        send(1, 1, 0); send(1, 0, 0); send(1, 0, 1);
        idle(4);
        got.delete();
        exp_q.delete();
        rand_prod(); send(1, 1, 0);
        rand_prod(); send(1, 0, 0);
        Reset = 1'b1;
        #1;
        check("T6 FI after reset", FI, 0);
        check("T6 FQ after reset", FQ, 0);
        check("T6 PushOut after reset", PushOut, 0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        idle(4);
        check("T6 pushes after reset", got.size(), 0);
        got.delete();
        rand_prod(); send(1, 1, 0);
        rand_prod(); send(1, 0, 0);
        rand_prod(); send(1, 0, 1);
        compare_queues("T6 next sample");

        // Randomized framing against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_prod();
            if ($urandom_range(0, 3) != 0)
                send(1, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            else
                idle(1);
        end
        compare_queues("random");
        check("random SeqErr", SeqErr, m_seq);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
